obi_rr_arbiter: RTL and testbench

- Shares one OBI memory port (scratchpad bank) among NUM_REQS OBI master lanes, e.g. the per-lane OBI outputs of the dcache-to-OBI bridge.
- Uses round-robin arbitration, keeps a locked selection while a request waits for grant, and routes in-order responses back to the issuing lane through an ID FIFO.
- Sits between the dcache bridge and the scratchpad or bus crossbar.

---
 rtl/obi_arb_pkg.sv | 19 +
 rtl/obi_arb_id_fifo.sv | 74 +++++++
 rtl/obi_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_obi_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared definitions for the OBI round-robin arbiter.
//   OBI_ADDR_W / OBI_DATA_W / OBI_BE_W : OBI bus field widths.
//   idx_width(n)                       : index width for n entries, at least 1.
package obi_arb_pkg;

   localparam int unsigned OBI_ADDR_W = 32'd32;
   localparam int unsigned OBI_DATA_W = 32'd32;
   localparam int unsigned OBI_BE_W   = 32'd4;

   // A single entry still needs a one-bit index so ports never collapse to zero width.
   function automatic int unsigned idx_width(input int unsigned n);
      if (n > 32'd1) begin
         return int'($clog2(n));
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Lane-ID FIFO: remembers which lane owns each granted, unanswered transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, data_i: write data_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   full_o/empty_o: occupancy flags
//   head_o        : oldest stored lane ID
// Push and pop in the same cycle keep the count unchanged.
module obi_arb_id_fifo
   import obi_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = idx_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign full_o    = (count_r == CNT_W'(DEPTH));
   assign empty_o   = (count_r == {CNT_W{1'b0}});
   assign head_o    = mem_r[rd_ptr_r];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI memory port among NUM_REQS OBI lanes.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   s_req_i / s_gnt_o    : per-lane request / zero-latency grant
//   s_we_i, s_be_i,
//   s_addr_i, s_wdata_i  : per-lane request fields
//   s_rvalid_o           : per-lane response valid, routed via the ID FIFO
//   s_rdata_o            : memory read data broadcast to all lanes
//   m_*                  : memory-side OBI port (responses return in order)
//   busy_o               : transactions outstanding or a request being presented
//   err_o                : sticky, a response arrived with nothing outstanding
// A lane presented without grant stays selected until granted so its fields
// remain stable on the memory port.
module obi_rr_arbiter
   import obi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQS        = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned IDX_W           = idx_width(NUM_REQS)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_REQS-1:0]                 s_req_i,
   output logic [NUM_REQS-1:0]                 s_gnt_o,
   input  logic [NUM_REQS-1:0]                 s_we_i,
   input  logic [NUM_REQS-1:0][OBI_BE_W-1:0]   s_be_i,
   input  logic [NUM_REQS-1:0][OBI_ADDR_W-1:0] s_addr_i,
   input  logic [NUM_REQS-1:0][OBI_DATA_W-1:0] s_wdata_i,
   output logic [NUM_REQS-1:0]                 s_rvalid_o,
   output logic [OBI_DATA_W-1:0]               s_rdata_o,
   output logic                                m_req_o,
   input  logic                                m_gnt_i,
   output logic                                m_we_o,
   output logic [OBI_BE_W-1:0]                 m_be_o,
   output logic [OBI_ADDR_W-1:0]               m_addr_o,
   output logic [OBI_DATA_W-1:0]               m_wdata_o,
   input  logic                                m_rvalid_i,
   input  logic [OBI_DATA_W-1:0]               m_rdata_i,
   output logic                                busy_o,
   output logic                                err_o
);

   logic [IDX_W-1:0] rr_ptr_r;
   logic             lock_r;
   logic [IDX_W-1:0] locked_idx_r;
   logic             err_r;

   logic [IDX_W-1:0] pick_s;
   logic [IDX_W-1:0] sel_s;
   logic [IDX_W-1:0] rr_next_s;
   logic [IDX_W-1:0] head_s;
   logic             m_req_s;
   logic             hs_s;
   logic             pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;

   // Round-robin search: walking from the far end down to rr_ptr makes the
   // last hit the first requester at or after rr_ptr.
   always_comb begin
      int               cand_v;
      logic [IDX_W-1:0] cand_idx;
      pick_s   = {IDX_W{1'b0}};
      cand_v   = 0;
      cand_idx = {IDX_W{1'b0}};
      for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
         cand_v   = (int'(rr_ptr_r) + i) % int'(NUM_REQS);
         cand_idx = IDX_W'(cand_v);
         pick_s   = s_req_i[cand_idx] ? cand_idx : pick_s;
      end
   end

   // The request is gated by reset so the port is quiet while reset is held;
   // the cap uses the registered count only, so m_rvalid_i never reaches m_req_o.
   assign sel_s     = lock_r ? locked_idx_r : pick_s;
   assign m_req_s   = rst_ni & (|s_req_i) & ~fifo_full_s;
   assign hs_s      = m_req_s & m_gnt_i;
   assign pop_s     = m_rvalid_i & ~fifo_empty_s;
   assign rr_next_s = (sel_s == IDX_W'(NUM_REQS - 1)) ? {IDX_W{1'b0}} : sel_s + IDX_W'(1);

   assign m_req_o   = m_req_s;
   assign s_rdata_o = m_rdata_i;
   assign busy_o    = ~fifo_empty_s | m_req_s;
   assign err_o     = err_r;

   // Memory-side request fields: selected lane, zero while not requesting.
   always_comb begin
      m_we_o    = 1'b0;
      m_be_o    = {OBI_BE_W{1'b0}};
      m_addr_o  = {OBI_ADDR_W{1'b0}};
      m_wdata_o = {OBI_DATA_W{1'b0}};
      if (m_req_s) begin
         m_we_o    = s_we_i[sel_s];
         m_be_o    = s_be_i[sel_s];
         m_addr_o  = s_addr_i[sel_s];
         m_wdata_o = s_wdata_i[sel_s];
      end else begin
         m_we_o    = 1'b0;
         m_be_o    = {OBI_BE_W{1'b0}};
         m_addr_o  = {OBI_ADDR_W{1'b0}};
         m_wdata_o = {OBI_DATA_W{1'b0}};
      end
   end

   // One-hot grant to the selected lane and response valid to the FIFO head.
   always_comb begin
      s_gnt_o    = {NUM_REQS{1'b0}};
      s_rvalid_o = {NUM_REQS{1'b0}};
      for (int i = 0; i < int'(NUM_REQS); i++) begin
         s_gnt_o[i]    = hs_s  & (sel_s  == IDX_W'(i));
         s_rvalid_o[i] = pop_s & (head_s == IDX_W'(i));
      end
   end

   // Round-robin pointer and lock on a presented-but-ungranted request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_r     <= {IDX_W{1'b0}};
         lock_r       <= 1'b0;
         locked_idx_r <= {IDX_W{1'b0}};
      end else if (hs_s) begin
         rr_ptr_r <= rr_next_s;
         lock_r   <= 1'b0;
      end else if (m_req_s) begin
         lock_r       <= 1'b1;
         locked_idx_r <= sel_s;
      end else begin
         rr_ptr_r     <= rr_ptr_r;
         lock_r       <= lock_r;
         locked_idx_r <= locked_idx_r;
      end
   end

   // Sticky flag for a response with no outstanding transaction.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | (m_rvalid_i & fifo_empty_s);
      end
   end

   obi_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs_s),
      .data_i  (sel_s),
      .pop_i   (pop_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .head_o  (head_s)
   );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Scoreboard bench for obi_rr_arbiter (NUM_REQS=4, MAX_OUTSTANDING=2).
// Directed stimulus pushes the expected grant lane / response into queues; a
// negedge monitor pops and compares whenever the DUT grants or responds.
module tb_obi_rr_arbiter;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [3:0]        req;
   logic [3:0]        s_gnt_o;
   logic [3:0]        we;
   logic [3:0][3:0]   be;
   logic [3:0][31:0]  addr;
   logic [3:0][31:0]  wdata;
   logic [3:0]        s_rvalid_o;
   logic [31:0]       s_rdata_o;
   logic              m_req_o;
   logic              m_gnt;
   logic              m_we_o;
   logic [3:0]        m_be_o;
   logic [31:0]       m_addr_o;
   logic [31:0]       m_wdata_o;
   logic              m_rvalid;
   logic [31:0]       m_rdata;
   logic              busy_o;
   logic              err_o;

   typedef struct packed {
      logic [3:0]  lanes;
      logic [31:0] data;
   } rsp_t;

   int unsigned exp_gnt_q[$];
   rsp_t        exp_rsp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic        hold_chk_r = 1'b0;
   logic [31:0] hold_addr_r = 32'd0;

   always #5 clk = ~clk;

   obi_rr_arbiter #(
      .NUM_REQS        (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .s_req_i    (req),
      .s_gnt_o    (s_gnt_o),
      .s_we_i     (we),
      .s_be_i     (be),
      .s_addr_i   (addr),
      .s_wdata_i  (wdata),
      .s_rvalid_o (s_rvalid_o),
      .s_rdata_o  (s_rdata_o),
      .m_req_o    (m_req_o),
      .m_gnt_i    (m_gnt),
      .m_we_o     (m_we_o),
      .m_be_o     (m_be_o),
      .m_addr_o   (m_addr_o),
      .m_wdata_o  (m_wdata_o),
      .m_rvalid_i (m_rvalid),
      .m_rdata_i  (m_rdata),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req      = 4'b0000;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 32'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_s_gnt", 32'(s_gnt_o), 32'd0);
      chk("rst_s_rvalid", 32'(s_rvalid_o), 32'd0);
      chk("rst_m_req", 32'(m_req_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      tick();
      rst_n = 1'b1;
   endtask

   // Monitor: compare every grant and response against the scoreboard queues,
   // and check that an ungranted request holds its address into the next cycle.
   always @(negedge clk) begin
      if (s_gnt_o != 4'b0000) begin
         if (exp_gnt_q.size() == 0) begin
            chk("gnt_unexpected", 32'(s_gnt_o), 32'd0);
         end else begin
            chk("gnt_lane", 32'(s_gnt_o), 32'd1 << exp_gnt_q[0]);
            void'(exp_gnt_q.pop_front());
         end
      end
      if (s_rvalid_o != 4'b0000) begin
         if (exp_rsp_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(s_rvalid_o), 32'd0);
         end else begin
            chk("rvalid_lane", 32'(s_rvalid_o), 32'(exp_rsp_q[0].lanes));
            chk("rdata", s_rdata_o, exp_rsp_q[0].data);
            void'(exp_rsp_q.pop_front());
         end
      end
      if (hold_chk_r && rst_n) begin
         chk("obi_hold_req", 32'(m_req_o), 32'd1);
         chk("obi_hold_addr", m_addr_o, hold_addr_r);
      end
      hold_chk_r  <= rst_n & m_req_o & ~m_gnt;
      hold_addr_r <= m_addr_o;
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      we    = 4'b0000;
      be    = {4{4'hF}};
      addr  = {4{32'd0}};
      wdata = {4{32'd0}};

      // Single lane read with response two cycles after grant.
      do_reset();
      req = 4'b0100; addr[2] = 32'h0000_0100; m_gnt = 1'b1;
      exp_gnt_q.push_back(2);
      @(negedge clk);
      chk("t1_m_req", 32'(m_req_o), 32'd1);
      chk("t1_m_addr", m_addr_o, 32'h0000_0100);
      chk("t1_m_we", 32'(m_we_o), 32'd0);
      chk("t1_m_be", 32'(m_be_o), 32'hF);
      tick(); idle();
      @(negedge clk);
      chk("t1_busy_wait", 32'(busy_o), 32'd1);
      chk("t1_addr_idle", m_addr_o, 32'd0);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
      exp_rsp_q.push_back('{lanes: 4'b0100, data: 32'hDEAD_BEEF});
      @(negedge clk);
      tick(); idle();
      @(negedge clk);
      chk("t1_err", 32'(err_o), 32'd0);
      chk("t1_busy_done", 32'(busy_o), 32'd0);

      // Fairness: all lanes request, memory grants every cycle, responds next cycle.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         addr[k]  = 32'h0000_1000 + 32'(4 * k);
         wdata[k] = 32'h5000_0000 + 32'(k);
      end
      we = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         req = 4'b1111; m_gnt = 1'b1;
         exp_gnt_q.push_back(c % 4);
         if (c > 0) begin
            m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + 32'(c);
            exp_rsp_q.push_back('{lanes: 4'b0001 << ((c - 1) % 4), data: 32'hA000_0000 + 32'(c)});
         end else begin
            m_rvalid = 1'b0;
         end
         @(negedge clk);
         chk("t2_m_addr", m_addr_o, 32'h0000_1000 + 32'(4 * (c % 4)));
         chk("t2_m_wdata", m_wdata_o, 32'h5000_0000 + 32'(c % 4));
         tick();
      end
      idle(); m_rvalid = 1'b1; m_rdata = 32'hA000_0005;
      exp_rsp_q.push_back('{lanes: 4'b0001, data: 32'hA000_0005});
      @(negedge clk);
      tick(); idle(); we = 4'b0000;

      // Lock: lane 1 waits three cycles; lane 0 appearing meanwhile must not steal it.
      do_reset();
      addr[0] = 32'h0000_0400; addr[1] = 32'h0000_0200; addr[3] = 32'h0000_0300;
      req = 4'b1010; m_gnt = 1'b0;
      for (int w = 0; w < 3; w++) begin
         if (w == 1) begin
            req = 4'b1011;
         end else begin
            req = req;
         end
         @(negedge clk);
         chk("t3_wait_addr", m_addr_o, 32'h0000_0200);
         chk("t3_wait_req", 32'(m_req_o), 32'd1);
         chk("t3_wait_gnt", 32'(s_gnt_o), 32'd0);
         tick();
      end
      m_gnt = 1'b1; exp_gnt_q.push_back(1);
      @(negedge clk);
      chk("t3_gnt1_addr", m_addr_o, 32'h0000_0200);
      tick();
      req = 4'b1001; m_rvalid = 1'b1; m_rdata = 32'h0000_0011;
      exp_gnt_q.push_back(3);
      exp_rsp_q.push_back('{lanes: 4'b0010, data: 32'h0000_0011});
      @(negedge clk);
      chk("t3_gnt3_addr", m_addr_o, 32'h0000_0300);
      tick();
      req = 4'b0001; m_rdata = 32'h0000_0033;
      exp_gnt_q.push_back(0);
      exp_rsp_q.push_back('{lanes: 4'b1000, data: 32'h0000_0033});
      @(negedge clk);
      chk("t3_gnt0_addr", m_addr_o, 32'h0000_0400);
      tick();
      req = 4'b0000; m_gnt = 1'b0; m_rdata = 32'h0000_0044;
      exp_rsp_q.push_back('{lanes: 4'b0001, data: 32'h0000_0044});
      @(negedge clk);
      tick(); idle();
      @(negedge clk);
      chk("t3_busy_done", 32'(busy_o), 32'd0);

      // Outstanding cap: two handshakes, then stall until one cycle after a response.
      do_reset();
      addr[0] = 32'h0000_0010; addr[1] = 32'h0000_0020; addr[2] = 32'h0000_0030;
      req = 4'b0111; m_gnt = 1'b1; exp_gnt_q.push_back(0);
      @(negedge clk);
      chk("t4_req_c0", 32'(m_req_o), 32'd1);
      tick();
      req = 4'b0110; exp_gnt_q.push_back(1);
      @(negedge clk);
      chk("t4_req_c1", 32'(m_req_o), 32'd1);
      tick();
      req = 4'b0100;
      @(negedge clk);
      chk("t4_req_full", 32'(m_req_o), 32'd0);
      chk("t4_gnt_full", 32'(s_gnt_o), 32'd0);
      chk("t4_busy_full", 32'(busy_o), 32'd1);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h0000_00C0;
      exp_rsp_q.push_back('{lanes: 4'b0001, data: 32'h0000_00C0});
      @(negedge clk);
      chk("t4_req_pop_cycle", 32'(m_req_o), 32'd0);
      tick();
      m_rvalid = 1'b0; exp_gnt_q.push_back(2);
      @(negedge clk);
      chk("t4_req_after_pop", 32'(m_req_o), 32'd1);
      chk("t4_addr_after_pop", m_addr_o, 32'h0000_0030);
      tick();
      req = 4'b0000; m_rvalid = 1'b1; m_rdata = 32'h0000_00C1;
      exp_rsp_q.push_back('{lanes: 4'b0010, data: 32'h0000_00C1});
      @(negedge clk);
      tick();
      m_rdata = 32'h0000_00C2;
      exp_rsp_q.push_back('{lanes: 4'b0100, data: 32'h0000_00C2});
      @(negedge clk);
      tick(); idle();
      @(negedge clk);
      chk("t4_busy_done", 32'(busy_o), 32'd0);

      // Simultaneous push and pop: grant lane 0 while lane 3's response returns.
      do_reset();
      addr[3] = 32'h0000_003C; addr[0] = 32'h0000_000C;
      req = 4'b1000; m_gnt = 1'b1; exp_gnt_q.push_back(3);
      @(negedge clk);
      tick();
      req = 4'b0001; m_rvalid = 1'b1; m_rdata = 32'h0000_0033;
      exp_gnt_q.push_back(0);
      exp_rsp_q.push_back('{lanes: 4'b1000, data: 32'h0000_0033});
      @(negedge clk);
      chk("t5_rvalid_vec", 32'(s_rvalid_o), 32'h8);
      chk("t5_addr", m_addr_o, 32'h0000_000C);
      tick();
      req = 4'b0000; m_gnt = 1'b0; m_rdata = 32'h0000_000C;
      exp_rsp_q.push_back('{lanes: 4'b0001, data: 32'h0000_000C});
      @(negedge clk);
      chk("t5_busy_count_kept", 32'(busy_o), 32'd1);
      tick(); idle();
      @(negedge clk);
      chk("t5_busy_done", 32'(busy_o), 32'd0);

      // Spurious response, then reset with two transactions in flight.
      do_reset();
      m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("t6_spurious_rvalid", 32'(s_rvalid_o), 32'd0);
      tick(); idle();
      @(negedge clk);
      chk("t6_err_set", 32'(err_o), 32'd1);
      tick();
      @(negedge clk);
      chk("t6_err_sticky", 32'(err_o), 32'd1);
      tick();
      addr[0] = 32'h0000_0A00; addr[1] = 32'h0000_0B00;
      req = 4'b0011; m_gnt = 1'b1; exp_gnt_q.push_back(0);
      @(negedge clk);
      tick();
      req = 4'b0010; exp_gnt_q.push_back(1);
      @(negedge clk);
      tick();
      rst_n = 1'b0; req = 4'b0011; m_gnt = 1'b1; m_rvalid = 1'b1;
      @(negedge clk);
      chk("t6_rst_m_req", 32'(m_req_o), 32'd0);
      chk("t6_rst_gnt", 32'(s_gnt_o), 32'd0);
      chk("t6_rst_rvalid", 32'(s_rvalid_o), 32'd0);
      chk("t6_rst_busy", 32'(busy_o), 32'd0);
      chk("t6_rst_err", 32'(err_o), 32'd0);
      chk("t6_rst_addr", m_addr_o, 32'd0);
      tick();
      rst_n = 1'b1; idle();
      @(negedge clk);
      chk("t6_fifo_empty", 32'(busy_o), 32'd0);
      chk("t6_err_clear", 32'(err_o), 32'd0);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h0000_1A7E;
      @(negedge clk);
      chk("t6_late_rvalid", 32'(s_rvalid_o), 32'd0);
      tick(); idle();
      @(negedge clk);
      chk("t6_late_err", 32'(err_o), 32'd1);
      tick();

      chk("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
      chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
